// File: rtl/io_input_conditioner_if.sv
// Signal bundle between the raw board inputs and the input-peripheral memory.
// The master side drives the raw switch/button levels and consumes the
// conditioned levels and pulses; the conditioner sits on the slave side.
interface io_input_conditioner_if #(
    parameter int SW_W  = 32,
    parameter int BTN_W = 4
);
    logic [SW_W-1:0]  i_sw_raw;
    logic [BTN_W-1:0] i_btn_raw;
    logic [SW_W-1:0]  o_io_sw;
    logic [BTN_W-1:0] o_io_btn;
    logic             o_sw_chg;
    logic [BTN_W-1:0] o_btn_press;
    logic [BTN_W-1:0] o_btn_rel;

    modport master (
        output i_sw_raw, i_btn_raw,
        input  o_io_sw, o_io_btn, o_sw_chg, o_btn_press, o_btn_rel
    );

    modport slave (
        input  i_sw_raw, i_btn_raw,
        output o_io_sw, o_io_btn, o_sw_chg, o_btn_press, o_btn_rel
    );
endinterface

// File: rtl/io_input_conditioner.sv
// Input conditioner for board switches and push-buttons.
// Each raw bit is synchronised, sampled on a slow prescaler tick and only
// accepted once STABLE_CNT consecutive tick samples agree. Level updates and
// their one-cycle change/press/release pulses are registered together.
// Switch and button bits share one datapath: bits [SW_W-1:0] are switches,
// bits [SW_W+BTN_W-1:SW_W] are buttons (already made active-high).
// SW_W/BTN_W must match the widths of the connected interface instance.
module io_input_conditioner #(
    parameter int SW_W           = 32,
    parameter int BTN_W          = 4,
    parameter bit BTN_ACTIVE_LOW = 1'b1,
    parameter int SYNC_STAGES    = 2,
    parameter int TICK_DIV       = 50000,
    parameter int STABLE_CNT     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    io_input_conditioner_if.slave io
);
    localparam int W     = SW_W + BTN_W;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]                  cnt;
    logic                              tick;
    logic [W-1:0]                      raw_in;
    logic [SYNC_STAGES-1:0][W-1:0]     sync_q;
    logic [W-1:0]                      sync_out;
    // Only the STABLE_CNT-1 previous samples need storing: the newest sample
    // of the window is the synchroniser output itself.
    logic [STABLE_CNT-2:0][W-1:0]      hist;
    logic [STABLE_CNT-1:0][W-1:0]      window;
    logic [W-1:0]                      all_one;
    logic [W-1:0]                      all_zero;
    logic [W-1:0]                      deb;
    logic [W-1:0]                      deb_next;
    logic                              sw_chg_q;
    logic [BTN_W-1:0]                  press_q;
    logic [BTN_W-1:0]                  rel_q;

    // Buttons are made active-high before synchronising so 0 is always idle.
    assign raw_in = {(BTN_ACTIVE_LOW ? ~io.i_btn_raw : io.i_btn_raw), io.i_sw_raw};

    // Prescaler: free-running 0..TICK_DIV-1, tick in the terminal-count cycle.
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == TICK_LAST);

    // Multi-flop synchroniser per bit; stage 0 takes the raw level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign window   = {hist, sync_out};

    // Candidate window agreement and the resulting next debounced level.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        all_one  = '1;
        all_zero = '1;
        for (int k = 0; k < STABLE_CNT; k++) begin
            all_one  &= window[k];
            all_zero &= ~window[k];
        end
        deb_next = (deb | all_one) & ~all_zero;
    end

    // Tick-driven history shift, level update and the matching one-cycle pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: history is cleared as well, so an input still held after reset must requalify from scratch.
            hist     <= '0;
            deb      <= '0;
            sw_chg_q <= 1'b0;
            press_q  <= '0;
            rel_q    <= '0;
        end else if (tick) begin
            hist     <= window[STABLE_CNT-2:0];
            deb      <= deb_next;
            sw_chg_q <= |(deb_next[SW_W-1:0] ^ deb[SW_W-1:0]);
            press_q  <= deb_next[W-1:SW_W] & ~deb[W-1:SW_W];
            rel_q    <= ~deb_next[W-1:SW_W] & deb[W-1:SW_W];
        end else begin
            sw_chg_q <= 1'b0;
            press_q  <= '0;
            rel_q    <= '0;
        end
    end

    assign io.o_io_sw     = deb[SW_W-1:0];
    assign io.o_io_btn    = deb[W-1:SW_W];
    assign io.o_sw_chg    = sw_chg_q;
    assign io.o_btn_press = press_q;
    assign io.o_btn_rel   = rel_q;
endmodule
